// File: rtl/clock_display_serializer.sv
// Converts binary h/m/s to BCD and streams MAX7219-style SPI frames (init, then 6 digits per refresh).
// Optional build macro CLOCK_DISPLAY_BLANK_LEADING_ZERO_EN sends a zero hours-tens digit as blank (4'hF).
module clock_display_serializer #(
  parameter int unsigned SYS_CLK_HZ = 50_000_000,
  parameter int unsigned SCLK_HZ    = 1_000_000,
  parameter logic [3:0]  INTENSITY  = 4'h8
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_stb,
  input  logic [5:0] i_seconds,
  input  logic [5:0] i_minutes,
  input  logic [4:0] i_hours,
  output logic       o_sclk,
  output logic       o_mosi,
  output logic       o_cs_n,
  output logic       o_busy,
  output logic       o_done
);
  localparam int unsigned HALF        = SYS_CLK_HZ / (2 * SCLK_HZ);
  localparam int unsigned DIV_W       = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned HALVES      = 34;
  localparam int unsigned INIT_FRAMES = 4;
  localparam int unsigned DISP_FRAMES = 6;

  if (HALF == 0) begin : g_bad_half
    $error("clock_display_serializer: SYS_CLK_HZ/(2*SCLK_HZ) must be >= 1");
  end

  typedef enum logic [1:0] {INIT, IDLE, LOAD, SEND} state_e;

  state_e           state_q;
  logic [2:0]       frame_q;
  logic [5:0]       half_q, half_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             act_q, pending_q;
  logic [5:0]       sec_q, min_q;
  logic [4:0]       hr_q;
  logic             sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d, busy_q, done_q;

  logic [5:0]  sec_v, min_v, nh;
  logic [4:0]  hr_v;
  logic [3:0]  sec_one, sec_ten, min_one, min_ten, hr_one, hr_ten, hr_ten_raw, bit_idx;
  logic [23:0] digs;
  logic [2:0]  start_idx;
  logic [15:0] cur_word, start_word;
  logic        half_end, frame_end, last_frame, start_frame;

  // Init words for the config phase, address/digit words for the display phase.
  function automatic logic [15:0] frame_word(input logic is_init, input logic [2:0] idx,
                                             input logic [23:0] dg);
    logic [3:0] d;
    case (idx)
      3'd0:    d = dg[3:0];
      3'd1:    d = dg[7:4];
      3'd2:    d = dg[11:8];
      3'd3:    d = dg[15:12];
      3'd4:    d = dg[19:16];
      default: d = dg[23:20];
    endcase
    if (is_init) begin
      case (idx)
        3'd0:    frame_word = 16'h0C01;
        3'd1:    frame_word = 16'h09FF;
        3'd2:    frame_word = 16'h0B05;
        default: frame_word = {8'h0A, 4'h0, INTENSITY};
      endcase
    end else begin
      frame_word = {4'h0, 4'(idx) + 4'd1, 4'h0, d};
    end
  endfunction

  // LOAD converts the live inputs so the first display frame can start on the next edge.
  assign sec_v = (state_q == LOAD) ? i_seconds : sec_q;
  assign min_v = (state_q == LOAD) ? i_minutes : min_q;
  assign hr_v  = (state_q == LOAD) ? i_hours   : hr_q;

  always_comb begin
    sec_one    = 4'(sec_v % 6'd10);
    sec_ten    = 4'(sec_v / 6'd10);
    min_one    = 4'(min_v % 6'd10);
    min_ten    = 4'(min_v / 6'd10);
    hr_one     = 4'(hr_v % 5'd10);
    hr_ten_raw = 4'(hr_v / 5'd10);
`ifdef CLOCK_DISPLAY_BLANK_LEADING_ZERO_EN
    hr_ten     = (hr_ten_raw == 4'h0) ? 4'hF : hr_ten_raw;
`else
    hr_ten     = hr_ten_raw;
`endif
    digs       = {hr_ten, hr_one, min_ten, min_one, sec_ten, sec_one};
  end

  // Frame position tracking and next-value computation for the serial outputs.
  always_comb begin
    half_end    = act_q && (div_q == DIV_W'(HALF - 1));
    frame_end   = half_end && (half_q == 6'(HALVES - 1));
    last_frame  = (state_q == INIT) ? (frame_q == 3'(INIT_FRAMES - 1))
                                    : (frame_q == 3'(DISP_FRAMES - 1));
    start_idx   = act_q ? frame_q + 3'd1 : 3'd0;
    cur_word    = frame_word(state_q == INIT, frame_q, digs);
    start_word  = frame_word(state_q == INIT, start_idx, digs);
    nh          = half_q + 6'd1;
    bit_idx     = 4'd15 - nh[4:1];
    start_frame = 1'b0;
    case (state_q)
      INIT:    start_frame = !act_q || (frame_end && !last_frame);
      LOAD:    start_frame = 1'b1;
      SEND:    start_frame = frame_end && !last_frame;
      default: start_frame = 1'b0;
    endcase

    sclk_d = sclk_q;
    mosi_d = mosi_q;
    cs_n_d = cs_n_q;
    div_d  = div_q;
    half_d = half_q;
    if (start_frame) begin
      div_d  = '0;
      half_d = '0;
      sclk_d = 1'b0;
      cs_n_d = 1'b0;
      mosi_d = start_word[15];
    end else if (frame_end) begin
      sclk_d = 1'b0;
      cs_n_d = 1'b1;
      mosi_d = 1'b0;
    end else if (half_end) begin
      div_d  = '0;
      half_d = nh;
      if (nh < 6'(HALVES - 2)) begin
        sclk_d = nh[0];
        mosi_d = cur_word[bit_idx];
        cs_n_d = 1'b0;
      end else begin
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        cs_n_d = (nh == 6'(HALVES - 1));
      end
    end else if (act_q) begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // Sequencing FSM with registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= INIT;
      frame_q   <= '0;
      half_q    <= '0;
      div_q     <= '0;
      act_q     <= 1'b0;
      pending_q <= 1'b0;
      sec_q     <= '0;
      min_q     <= '0;
      hr_q      <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      cs_n_q <= cs_n_d;
      div_q  <= div_d;
      half_q <= half_d;
      done_q <= 1'b0;
      case (state_q)
        INIT: begin
          if (i_stb) pending_q <= 1'b1;
          if (start_frame) begin
            frame_q <= start_idx;
            act_q   <= 1'b1;
          end else if (frame_end) begin
            state_q <= LOAD;
            frame_q <= '0;
            act_q   <= 1'b0;
          end
        end
        LOAD: begin
          sec_q     <= i_seconds;
          min_q     <= i_minutes;
          hr_q      <= i_hours;
          pending_q <= i_stb;
          frame_q   <= '0;
          act_q     <= 1'b1;
          state_q   <= SEND;
        end
        SEND: begin
          if (i_stb) pending_q <= 1'b1;
          if (start_frame) begin
            frame_q <= start_idx;
          end else if (frame_end) begin
            frame_q <= '0;
            act_q   <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= pending_q | i_stb;
            state_q <= (pending_q | i_stb) ? LOAD : IDLE;
          end
        end
        default: begin
          if (i_stb) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign o_sclk = sclk_q;
  assign o_mosi = mosi_q;
  assign o_cs_n = cs_n_q;
  assign o_busy = busy_q;
  assign o_done = done_q;
endmodule

// File: tb/tb_clock_display_serializer.sv
// Bench for clock_display_serializer: decodes the SPI stream into 16-bit words and compares them
// with words computed from h/m/s arithmetic; also checks SCLK/CS timing and busy/done behaviour.
module tb_clock_display_serializer;
  localparam int unsigned SYS_HZ = 6_000_000;
  localparam int unsigned SPI_HZ = 1_000_000;
  localparam int unsigned HALF   = SYS_HZ / (2 * SPI_HZ);
`ifdef CLOCK_DISPLAY_BLANK_LEADING_ZERO_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stb = 1'b0;
  logic [5:0] sec = '0;
  logic [5:0] mins = '0;
  logic [4:0] hrs = '0;
  logic       sclk, mosi, cs_n, busy, done;

  always #5 clk = ~clk;

  clock_display_serializer #(.SYS_CLK_HZ(SYS_HZ), .SCLK_HZ(SPI_HZ), .INTENSITY(4'h8)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_stb(stb),
    .i_seconds(sec), .i_minutes(mins), .i_hours(hrs),
    .o_sclk(sclk), .o_mosi(mosi), .o_cs_n(cs_n), .o_busy(busy), .o_done(done)
  );

  // SPI decoder / timing monitor, sampling on the falling clock edge.
  logic [15:0] frames[$];
  int unsigned ncyc = 0, done_cnt = 0, bitcnt = 0, last_rise = 0, low_start = 0, cs_rise = 0;
  int unsigned per_min = 9999, per_max = 0, low_min = 9999, low_max = 0, gap_min = 9999;
  int unsigned unstable = 0, last_stb = 0, stb_to_fall = 0;
  logic [15:0] shreg = '0;
  logic prev_sclk = 1'b0, prev_cs = 1'b1, prev_mosi = 1'b0, fall_armed = 1'b0, rise_ok = 1'b0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      ncyc++;
      if (stb) begin
        last_stb   = ncyc;
        fall_armed = 1'b1;
      end
      if (prev_cs && !cs_n) begin
        bitcnt    = 0;
        low_start = ncyc;
        if (fall_armed) begin
          stb_to_fall = ncyc - last_stb;
          fall_armed  = 1'b0;
        end
        if (rise_ok && (ncyc - cs_rise) < gap_min) gap_min = ncyc - cs_rise;
      end
      if (!prev_sclk && sclk && !cs_n) begin
        if (mosi !== prev_mosi) unstable++;
        if (bitcnt > 0) begin
          if ((ncyc - last_rise) < per_min) per_min = ncyc - last_rise;
          if ((ncyc - last_rise) > per_max) per_max = ncyc - last_rise;
        end
        last_rise = ncyc;
        shreg     = {shreg[14:0], mosi};
        bitcnt++;
      end
      if (!prev_cs && cs_n) begin
        rise_ok = (bitcnt == 16) && rst_n;
        if (rise_ok) begin
          frames.push_back(shreg);
          if ((ncyc - low_start) < low_min) low_min = ncyc - low_start;
          if ((ncyc - low_start) > low_max) low_max = ncyc - low_start;
          cs_rise = ncyc;
        end
      end
      if (done) done_cnt++;
      prev_sclk = sclk;
      prev_cs   = cs_n;
      prev_mosi = mosi;
    end
  end

  int unsigned checks = 0, failures = 0, rd_idx = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: address i+1 carries digit i of sec-ones, sec-tens, min-ones, min-tens, hr-ones, hr-tens.
  function automatic logic [15:0] disp_word(input int i, input int h, input int m, input int s);
    int v[6];
    int d;
    v = '{s % 10, s / 10, m % 10, m / 10, h % 10, h / 10};
    d = v[i];
    if (i == 5 && d == 0 && BLANK) d = 15;
    return 16'((i + 1) * 256 + d);
  endfunction

  task automatic check_frame(input string tag, input logic [15:0] exp);
    logic [31:0] obs;
    obs = (rd_idx < frames.size()) ? {16'h0, frames[rd_idx]} : 32'h1_0000;
    check(tag, obs, {16'h0, exp});
    rd_idx++;
  endtask

  task automatic expect_init();
    logic [15:0] w[4];
    w = '{16'h0C01, 16'h09FF, 16'h0B05, 16'h0A08};
    for (int i = 0; i < 4; i++) check_frame($sformatf("init_frame%0d", i), w[i]);
  endtask

  task automatic expect_refresh(input string tag, input int h, input int m, input int s);
    for (int i = 0; i < 6; i++)
      check_frame($sformatf("%s_frame%0d", tag, i), disp_word(i, h, m, s));
  endtask

  task automatic wait_done(input string tag, input int unsigned target, input int unsigned budget);
    int unsigned n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_timeout"}, 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    @(posedge clk);
    #1;
    hrs  = 5'(h);
    mins = 6'(m);
    sec  = 6'(s);
  endtask

  task automatic pulse_stb();
    @(posedge clk);
    #1 stb = 1'b1;
    @(posedge clk);
    #1 stb = 1'b0;
  endtask

  task automatic refresh(input string tag, input int h, input int m, input int s);
    int unsigned base;
    set_time(h, m, s);
    base = done_cnt;
    pulse_stb();
    wait_done(tag, base + 1, 2000);
    repeat (4) @(negedge clk);
    expect_refresh(tag, h, m, s);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin : main
    int h0, m0, s0, base, n;
    h0 = int'($urandom_range(23));
    m0 = int'($urandom_range(59));
    s0 = int'($urandom_range(59));
    hrs = 5'(h0); mins = 6'(m0); sec = 6'(s0);
    repeat (3) @(negedge clk);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_done", 32'(done), 32'd0);

    // Power-up: init frames then one automatic refresh.
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("init_busy", 32'(busy), 32'd1);
    wait_done("powerup", 1, 3000);
    repeat (300) @(negedge clk);
    expect_init();
    expect_refresh("auto", h0, m0, s0);
    check("auto_done_count", done_cnt, 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_mosi", 32'(mosi), 32'd0);
    check("idle_cs_n", 32'(cs_n), 32'd1);
    check("idle_sclk", 32'(sclk), 32'd0);

    refresh("t123456", 12, 34, 56);
    check("stb_to_cs_fall", stb_to_fall, 32'd2);
    refresh("t070000", 7, 0, 0);
    for (int k = 0; k < 3; k++)
      refresh($sformatf("rnd%0d", k), int'($urandom_range(23)), int'($urandom_range(59)),
              int'($urandom_range(59)));
    refresh("oor", 31, 63, 63);

    // Requests during a refresh collapse into one refresh using the later inputs.
    h0 = int'($urandom_range(23));
    m0 = int'($urandom_range(59));
    s0 = int'($urandom_range(59));
    set_time(h0, m0, s0);
    base = int'(done_cnt);
    pulse_stb();
    repeat (20) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(20, 120)) @(negedge clk);
      pulse_stb();
    end
    set_time(23, 59, 59);
    check("multi_stb_in_window", done_cnt, 32'(base));
    wait_done("multi", 32'(base + 2), 3000);
    repeat (1500) @(negedge clk);
    check("multi_done_count", done_cnt, 32'(base + 2));
    check("multi_idle_busy", 32'(busy), 32'd0);
    expect_refresh("multi_a", h0, m0, s0);
    expect_refresh("multi_b", 23, 59, 59);

    // Asynchronous reset in the middle of a refresh frame.
    h0 = int'($urandom_range(23));
    m0 = int'($urandom_range(59));
    s0 = int'($urandom_range(59));
    set_time(h0, m0, s0);
    base = int'(done_cnt);
    pulse_stb();
    n = 0;
    while (cs_n && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_test_cs_low", 32'(cs_n), 32'd0);
    repeat ($urandom_range(4, 60)) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_cs_n", 32'(cs_n), 32'd1);
    check("async_sclk", 32'(sclk), 32'd0);
    check("async_busy", 32'(busy), 32'd1);
    check("async_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    rd_idx = frames.size();
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_done("post_reset", 32'(base + 1), 3000);
    repeat (20) @(negedge clk);
    expect_init();
    expect_refresh("post_reset", h0, m0, s0);

    // Serial timing and stream integrity over the whole run.
    check("sclk_period_min", per_min, 2 * HALF);
    check("sclk_period_max", per_max, 2 * HALF);
    check("cs_low_len_min", low_min, 33 * HALF);
    check("cs_low_len_max", low_max, 33 * HALF);
    check("frame_gap_min", gap_min, HALF);
    check("mosi_stable_at_rise", unstable, 32'd0);
    check("no_extra_frames", frames.size(), rd_idx);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
